// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-in, serial-out shift register.
// Accepts a word through a valid/ready load handshake and streams it out one
// bit per enabled clock, MSB-first (dir=0) or LSB-first (dir=1). A bit counter
// ends the frame and done pulses in the cycle after the last bit is consumed.
// Optional feature: define PISO_PARITY_EN to append an even-parity bit
// (XOR of all data bits) after the last data bit.
module piso_shift_reg #(
    parameter int MSB = 16
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           en,
    input  logic           dir,
    input  logic           load_valid,
    output logic           load_ready,
    input  logic [MSB-1:0] din,
    output logic           q,
    output logic           q_valid,
    output logic           done,
    output logic           busy
);

    localparam int CW = (MSB > 1) ? $clog2(MSB) : 1;

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t          state, state_n;
    logic [MSB-1:0]  sreg, sreg_n;
    logic            dir_q, dir_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            done_q, done_n;
`ifdef PISO_PARITY_EN
    logic            par_q, par_n;
`endif

    // Next-state, shift and counter logic for the frame sequencer.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        state_n = state;
        sreg_n  = sreg;
        dir_n   = dir_q;
        cnt_n   = cnt;
        done_n  = 1'b0;
`ifdef PISO_PARITY_EN
        par_n   = par_q;
`endif
        case (state)
            IDLE: begin
                // Acceptance is independent of en.
                if (load_valid) begin
                    sreg_n  = din;
                    dir_n   = dir;
                    cnt_n   = CW'(MSB - 1);
                    state_n = SHIFT;
`ifdef PISO_PARITY_EN
                    par_n   = ^din;
`endif
                end
            end
            SHIFT: begin
                if (en) begin
                    if (cnt != '0) begin
                        // Move the next bit into the output position.
                        sreg_n = dir_q ? (sreg >> 1) : (sreg << 1);
                        cnt_n  = cnt - CW'(1);
                    end else begin
`ifdef PISO_PARITY_EN
                        state_n = PAR;
`else
                        state_n = IDLE;
                        done_n  = 1'b1;
`endif
                    end
                end
            end
`ifdef PISO_PARITY_EN
            PAR: begin
                if (en) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset; reset abandons any frame.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rstn) begin
            state  <= IDLE;
            sreg   <= '0;
            dir_q  <= 1'b0;
            cnt    <= '0;
            done_q <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q  <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            sreg   <= sreg_n;
            dir_q  <= dir_n;
            cnt    <= cnt_n;
            done_q <= done_n;
`ifdef PISO_PARITY_EN
            par_q  <= par_n;
`endif
        end
    end

    // Output decode: q is forced low outside a frame.
    always_comb begin
        load_ready = (state == IDLE);
        busy       = ~load_ready;
        q_valid    = (state != IDLE);
        done       = done_q;
        q          = 1'b0;
        case (state)
            SHIFT:   q = dir_q ? sreg[0] : sreg[MSB-1];
`ifdef PISO_PARITY_EN
            PAR:     q = par_q;
`endif
            default: q = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_piso_shift_reg.sv
// tb_piso_shift_reg: directed self-checking bench for piso_shift_reg (MSB=16).
// Inputs change at negedge or just after posedge; outputs are sampled at negedge.
module tb_piso_shift_reg;

    logic        clk = 1'b0;
    logic        rstn, en, dir, load_valid;
    logic        load_ready, q, q_valid, done, busy;
    logic [15:0] din;

    int n_checks = 0;
    int n_pass   = 0;

    piso_shift_reg #(.MSB(16)) dut (
        .clk(clk), .rstn(rstn), .en(en), .dir(dir),
        .load_valid(load_valid), .load_ready(load_ready), .din(din),
        .q(q), .q_valid(q_valid), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

`ifdef PISO_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    // Load a word, consume the frame, and compare the serial stream with the
    // hand-computed bit sequence (first bit in bit 15). Optionally stalls en for
    // three cycles after the 5th bit, and optionally pokes dir/load_valid mid-frame.
    task automatic run_frame(input string tag, input logic [15:0] word, input logic d,
                             input logic [15:0] exp_bits, input logic exp_par,
                             input bit do_stall, input logic stall_bit, input bit poke);
        logic [15:0] bits;
        int nb, cyc, stalls, wait_cyc, done_seen, qv_bad;
        bits = '0; nb = 0; cyc = 0; stalls = 0; done_seen = 0; qv_bad = 0;
        wait_cyc = 0;
        @(negedge clk);
        while (!load_ready && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        check({tag, "_ready"}, {31'd0, load_ready}, 32'd1);
        din = word; dir = d; load_valid = 1'b1; en = 1'b1;
        @(posedge clk);
        #1 load_valid = 1'b0;
        while (nb < 16 + PAR_BITS && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done) done_seen++;
            if (!q_valid) qv_bad++;
            if (do_stall && nb == 5 && stalls < 3) begin
                en = 1'b0;
                stalls++;
                check({tag, "_stall_hold"}, {31'd0, q}, {31'd0, stall_bit});
            end else begin
                en = 1'b1;
                if (do_stall && nb == 5)
                    check({tag, "_stall_last"}, {31'd0, q}, {31'd0, stall_bit});
                if (nb < 16) bits = {bits[14:0], q};
                else check({tag, "_parity"}, {31'd0, q}, {31'd0, exp_par});
                nb++;
                if (poke && nb == 4) begin
                    dir = ~d; din = 16'hFFFF; load_valid = 1'b1;
                end else begin
                    load_valid = 1'b0;
                end
            end
        end
        load_valid = 1'b0;
        check({tag, "_bits"}, {16'd0, bits}, {16'd0, exp_bits});
        check({tag, "_no_early_done"}, done_seen, 0);
        check({tag, "_qvalid"}, qv_bad, 0);
        @(negedge clk);
        cyc++;
        check({tag, "_done"}, {30'd0, done, load_ready}, 32'd3);
        check({tag, "_done_cycle"}, cyc, 17 + PAR_BITS + (do_stall ? 3 : 0));
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; dir = 1'b0; load_valid = 1'b0; din = '0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("reset_out", {28'd0, q, q_valid, done, busy}, 32'd0);
        check("reset_ready", {31'd0, load_ready}, 32'd1);

        // MSB-first and LSB-first of A5C3 (8 ones -> parity 0).
        run_frame("msb", 16'hA5C3, 1'b0, 16'b1010_0101_1100_0011, 1'b0, 0, 1'b0, 0);
        run_frame("lsb", 16'hA5C3, 1'b1, 16'b1100_0011_1010_0101, 1'b0, 0, 1'b0, 0);
        // Single set bit LSB-first: one first, then zeros; parity 1.
        run_frame("lsb1", 16'h0001, 1'b1, 16'b1000_0000_0000_0000, 1'b1, 0, 1'b0, 0);
        // Stall after the 5th bit: 6th bit of 1010_01.. is 1.
        run_frame("stall", 16'hA5C3, 1'b0, 16'b1010_0101_1100_0011, 1'b0, 1, 1'b1, 0);
        // dir toggle and load_valid with a new word mid-frame are ignored.
        run_frame("ignore", 16'h3C5A, 1'b0, 16'b0011_1100_0101_1010, 1'b0, 0, 1'b0, 1);

        // Reset mid-frame after 8 bits.
        @(negedge clk);
        din = 16'hA5C3; dir = 1'b0; load_valid = 1'b1; en = 1'b1;
        @(posedge clk);
        #1 load_valid = 1'b0;
        repeat (8) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_out", {28'd0, q, q_valid, done, busy}, 32'd0);
        check("midrst_ready", {31'd0, load_ready}, 32'd1);
        rstn = 1'b1;
        @(negedge clk);
        check("midrst_no_done", {31'd0, done}, 32'd0);
        run_frame("after_rst", 16'h0F0F, 1'b0, 16'b0000_1111_0000_1111, 1'b0, 0, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/piso_shift_reg.md
# piso_shift_reg

Parallel-in, serial-out shift register: the transmit-side counterpart of the team's 16-bit serial-in/parallel-out `shift_reg`. It accepts a MSB-bit word through a valid/ready load handshake and streams it out one bit per enabled clock. Shift order is selectable: MSB-first or LSB-first. A bit counter ends the frame, and `done` pulses when the frame completes. It feeds serial links and is the stimulus source for `shift_reg` in loopback benches.

## Interface
- `MSB`, 16, word width in bits (≥2).
- `clk`  in  1  clock; all state changes on rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `en`  in  1  shift enable; the current bit is consumed on edges where `en`=1.
- `dir`  in  1  shift order, sampled at load: 0 = MSB-first, 1 = LSB-first.
- `load_valid`  in  1  `din` holds a word to send.
- `load_ready`  out  1  block is idle and will accept a load.
- `din`  in  MSB  parallel word.
- `q`  out  1  serial data bit.
- `q_valid`  out  1  `q` holds a frame bit.
- `done`  out  1  one-cycle pulse after the last frame bit is consumed.
- `busy`  out  1  equals ~`load_ready`.

## Operation
- State machine:
  - IDLE, SHIFT, and PAR (PAR exists only with the macro).
  - Internal registers: MSB-bit shift register, latched direction bit, bit counter of width clog2(MSB).
- IDLE:
  - `load_ready`=1, `q_valid`=0, `q`=0.
  - A load is accepted on an edge where `load_valid`=1. Acceptance does not depend on `en`.
  - On acceptance, latch `din` and `dir`, set the counter to MSB-1, and go to SHIFT.
  - `q` takes the first bit: `din[MSB-1]` if `dir`=0, or `din[0]` if `dir`=1.
- SHIFT:
  - `q_valid`=1 and `load_ready`=0.
  - On each edge with `en`=1 and counter≠0:
    - shift the register toward the output end;
    - decrement the counter;
    - `q` takes the next bit.
  - On an edge with `en`=1 and counter=0, the last data bit has been consumed:
    - go to PAR if the macro is defined;
    - otherwise go to IDLE with `done`=1 for one cycle.
- `en`=0 in SHIFT or PAR: everything holds, including `q`, `q_valid` and the counter.
- Changes on `dir` or `din` after acceptance are ignored until the next load.
- `load_valid` outside IDLE is ignored; no word is queued.
- Consumer rule: sample `q` on every edge where `q_valid`=1 and `en`=1.

## Timing
- After any edge with `rstn`=0, regardless of state:
  - state=IDLE;
  - `q`=0, `q_valid`=0, `done`=0, `busy`=0;
  - `load_ready`=1;
  - shift register and counter cleared.
  - Reset mid-frame abandons the frame and produces no `done`.
- Load latency: the first bit appears on `q` in the cycle after the accept edge.
- Frame length: MSB bits (MSB+1 with parity), plus one cycle per stalled edge.
- `done` is high in the cycle after the final consuming edge. That cycle is the same one where `load_ready` returns to 1.
- Back-to-back frames: the minimum gap between frames is one IDLE cycle. Bits from two frames are never adjacent without a gap.

## Configuration
- Macro `PISO_PARITY_EN`.
- Defined:
  - After the last data bit, state PAR presents `q` = XOR of all latched data bits (even parity).
  - This is one extra bit with `q_valid`=1, consumed on the next edge with `en`=1.
  - That edge moves to IDLE with `done`=1.
- Undefined:
  - PAR state and parity logic are absent.
  - Frame is exactly MSB bits.

## Test plan
- **Reset default:** hold `rstn`=0 for 2 edges, then release → `q`=0, `q_valid`=0, `done`=0, `load_ready`=1.
- **MSB-first:** MSB=16, `din`=16'hA5C3, `dir`=0, `en`=1 →
  - `q` = 1010_0101_1100_0011 over 16 cycles;
  - `done` in cycle 17; with parity, a 17th bit of 0 and `done` in cycle 18.
- **LSB-first:** `din`=16'hA5C3, `dir`=1 →
  - `q` = 1100_0011_1010_0101;
  - with parity, `din`=16'h0001 gives a final parity bit of 1.
- **Stall:** `en`=0 for 3 cycles after the 5th bit → the 6th bit is held on `q` for 4 cycles, and `done` arrives 3 cycles late.
- **Ignored inputs:** toggle `dir` mid-frame and assert `load_valid` with a new `din` mid-frame → output unchanged, new word not accepted.
- **Reset mid-frame:** assert reset after bit 8 → next edge `q_valid`=0, with no `done`. A new load of 16'h0F0F then shifts out correctly.
